axil_rd_timeout: RTL

// - Per-lane AXI4-lite read watchdog between one m_axil read lane of the read fan-out stage and its slave.
// - Forwards one read at a time. If the slave does not respond within TIMEOUT cycles, it returns SLVERR/ERR_DATA upstream so the fan-out never hangs.
// - Any late slave response is drained and discarded.

---
 rtl/axil_pkg.sv | 18 +
 rtl/axil_timeout_ctr.sv | 39 +++
 rtl/axil_rd_timeout.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared constants for the AXI4-lite read watchdog: response codes, FSM state
// encoding and a saturating increment used by the optional statistics counter.
package axil_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axil_timeout_ctr.sv
// Watchdog cycle counter: cleared on a new read, counts while enabled and
// saturates at TIMEOUT-1, where 'expire' is asserted combinationally.
module axil_timeout_ctr #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned   CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = (cnt_q == LAST);

  // Saturating keeps the budget exhausted if an AR handshake lands on the
  // expiry cycle, so the data phase times out on its first idle cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expire) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axil_rd_timeout.sv
// Per-lane AXI4-lite read watchdog: forwards one read at a time and forces a
// SLVERR response if the slave stalls. Optional stats: AXIL_RD_TIMEOUT_STATS_EN.
module axil_rd_timeout
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [63:0] ERR_DATA   = 64'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic                  timeout_pulse
`ifdef AXIL_RD_TIMEOUT_STATS_EN
  ,
  output logic [15:0]           timeout_count
`endif
);

  localparam logic [DATA_WIDTH-1:0] ERR_DATA_W = DATA_WIDTH'(ERR_DATA);

  logic [2:0]            state_q, state_d;
  logic                  ar_pend_q, ar_pend_d;
  logic                  r_owe_q, r_owe_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [2:0]            arprot_q, arprot_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  s_arready_q, s_arready_d;
  logic                  s_rvalid_q, s_rvalid_d;
  logic                  m_arvalid_q, m_arvalid_d;
  logic                  m_rready_q, m_rready_d;
  logic                  timeout_pulse_q, timeout_pulse_d;

  logic s_ar_hs, s_r_hs, m_ar_hs, m_r_hs;
  logic ctr_clear, ctr_enable, expire;

  assign s_ar_hs = s_axil_arvalid && s_arready_q;
  assign s_r_hs  = s_rvalid_q && s_axil_rready;
  assign m_ar_hs = m_arvalid_q && m_axil_arready;
  assign m_r_hs  = m_axil_rvalid && m_rready_q;

  assign ctr_clear  = (state_q == ST_IDLE) && s_ar_hs;
  assign ctr_enable = (state_q == ST_ADDR) || (state_q == ST_DATA);

  axil_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (ctr_clear),
    .enable (ctr_enable),
    .expire (expire)
  );

  always_comb begin
    state_d         = state_q;
    ar_pend_d       = ar_pend_q;
    r_owe_d         = r_owe_q;
    araddr_d        = araddr_q;
    arprot_d        = arprot_q;
    rdata_d         = rdata_q;
    rresp_d         = rresp_q;
    timeout_pulse_d = 1'b0;

    // An abandoned AR that finally gets accepted now owes us a discarded R beat.
    if (ar_pend_q && m_ar_hs) begin
      ar_pend_d = 1'b0;
      r_owe_d   = 1'b1;
    end
    if (r_owe_q && m_r_hs) begin
      r_owe_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (s_ar_hs) begin
          araddr_d = s_axil_araddr;
          arprot_d = s_axil_arprot;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_ar_hs) begin
          state_d = ST_DATA;
        end else if (expire) begin
          rdata_d         = ERR_DATA_W;
          rresp_d         = AXIL_RESP_SLVERR;
          timeout_pulse_d = 1'b1;
          ar_pend_d       = 1'b1;
          state_d         = ST_RESP;
        end
      end
      ST_DATA: begin
        if (m_r_hs) begin
          rdata_d = m_axil_rdata;
          rresp_d = m_axil_rresp;
          state_d = ST_RESP;
        end else if (expire) begin
          rdata_d         = ERR_DATA_W;
          rresp_d         = AXIL_RESP_SLVERR;
          timeout_pulse_d = 1'b1;
          r_owe_d         = 1'b1;
          state_d         = ST_RESP;
        end
      end
      ST_RESP: begin
        if (s_r_hs) begin
          state_d = (ar_pend_d || r_owe_d) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!ar_pend_d && !r_owe_d) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs are registered from the next state.
    s_arready_d = (state_d == ST_IDLE);
    s_rvalid_d  = (state_d == ST_RESP);
    m_arvalid_d = (state_d == ST_ADDR) || ar_pend_d;
    m_rready_d  = (state_d == ST_DATA) || r_owe_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      ar_pend_q       <= 1'b0;
      r_owe_q         <= 1'b0;
      araddr_q        <= '0;
      arprot_q        <= '0;
      rdata_q         <= '0;
      rresp_q         <= '0;
      s_arready_q     <= 1'b0;
      s_rvalid_q      <= 1'b0;
      m_arvalid_q     <= 1'b0;
      m_rready_q      <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ar_pend_q       <= ar_pend_d;
      r_owe_q         <= r_owe_d;
      araddr_q        <= araddr_d;
      arprot_q        <= arprot_d;
      rdata_q         <= rdata_d;
      rresp_q         <= rresp_d;
      s_arready_q     <= s_arready_d;
      s_rvalid_q      <= s_rvalid_d;
      m_arvalid_q     <= m_arvalid_d;
      m_rready_q      <= m_rready_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign s_axil_arready = s_arready_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rvalid  = s_rvalid_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = arprot_q;
  assign m_axil_arvalid = m_arvalid_q;
  assign m_axil_rready  = m_rready_q;
  assign timeout_pulse  = timeout_pulse_q;

`ifdef AXIL_RD_TIMEOUT_STATS_EN
  logic [15:0] timeout_count_q, timeout_count_d;

  always_comb begin
    timeout_count_d = timeout_count_q;
    if (timeout_pulse_q) begin
      timeout_count_d = sat_inc16(timeout_count_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_count_q <= '0;
    end else begin
      timeout_count_q <= timeout_count_d;
    end
  end

  assign timeout_count = timeout_count_q;
`endif

endmodule
